// File: rtl/quad_enc_pkg.sv
// Purpose: shared quadrature constants, decode result type and decode helper.
// Latency: pure combinational helpers, no state.
// Backpressure: none; every decoded step is consumed in the cycle it is produced.
package quad_enc_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Result of comparing two consecutive {A,B} samples.
  typedef struct packed {
    logic              valid;  // exactly one bit changed
    logic              err;    // both bits changed at once
    logic signed [1:0] delta;  // +1 CW, -1 CCW, 0 otherwise
  } qstep_t;

  // Successor of a state in the clockwise Gray sequence 00->01->11->10->00.
  function automatic logic [1:0] quad_next_cw(input logic [1:0] s);
    case (s)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

  function automatic qstep_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    qstep_t r;
    r.valid = 1'b0;
    r.err   = 1'b0;
    r.delta = 2'sd0;
    if ((prev ^ cur) == 2'b11) begin
      r.err = 1'b1;
    end else if (prev != cur) begin
      r.valid = 1'b1;
      r.delta = (cur == quad_next_cw(prev)) ? 2'sd1 : -2'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_enc_ctrl_if.sv
// Purpose: bundles encoder pins, host load port and event outputs of the controller.
// Latency: wiring only.
// Backpressure: none; events are single-cycle pulses consumers must sample.
interface quad_enc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             enc_btn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic             tick;
  logic             dir;
  logic             limit;
  logic             btn_press;
  logic             err;

  // Pins/host side: drives the raw inputs and load, observes the results.
  modport master (
    output enc_a, enc_b, enc_btn, load, load_val,
    input  value, tick, dir, limit, btn_press, err
  );

  // Controller side.
  modport slave (
    input  enc_a, enc_b, enc_btn, load, load_val,
    output value, tick, dir, limit, btn_press, err
  );
endinterface

// File: rtl/sync_filter.sv
// Purpose: 2-flop synchroniser followed by a FILT-sample stability filter for one raw pin.
// Latency: pin change seen at edge k+1 appears on dout_o at edge k+2+FILT.
// Backpressure: none; output level simply follows the stable input.
module sync_filter #(
  parameter int   FILT    = 3,
  parameter logic RST_LVL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  localparam int             CW       = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= RST_LVL;
      s2_q <= RST_LVL;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level on the FILT-th consecutive differing sample; any agreeing sample restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filtered level and run-length counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q <= RST_LVL;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o = lvl_q;

endmodule

// File: rtl/quad_enc_ctrl.sv
// Purpose: quadrature decoder with detent sub-counter, bounded/wrapping value and event pulses.
// Latency: raw pin change after edge k -> outputs registered at edge k+3+FILT; load visible after next edge.
// Backpressure: none; at most one transition per cycle, pulses are one cycle wide and not held.
module quad_enc_ctrl
  import quad_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FILT      = 3,
  parameter int STEPS     = 4,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 255,
  parameter int RESET_VAL = 8,
  parameter int WRAP      = 0
) (
  input  logic           clk,
  input  logic           rst,
  quad_enc_ctrl_if.slave bus
);

  localparam int                XW      = WIDTH + 1;
  localparam logic [XW-1:0]     MINX    = XW'(MIN_VAL);
  localparam logic [XW-1:0]     MAXX    = XW'(MAX_VAL);
  localparam logic signed [3:0] SUB_TOP = 4'(STEPS - 1);
  localparam logic signed [3:0] SUB_BOT = 4'(1 - STEPS);

  logic a_f;
  logic b_f;
  logic btn_f;

  sync_filter #(.FILT(FILT), .RST_LVL(1'b1)) u_filt_a (
    .clk(clk), .rst(rst), .din_i(bus.enc_a), .dout_o(a_f)
  );
  sync_filter #(.FILT(FILT), .RST_LVL(1'b1)) u_filt_b (
    .clk(clk), .rst(rst), .din_i(bus.enc_b), .dout_o(b_f)
  );
  sync_filter #(.FILT(FILT), .RST_LVL(1'b1)) u_filt_btn (
    .clk(clk), .rst(rst), .din_i(bus.enc_btn), .dout_o(btn_f)
  );

  logic [1:0]        quad_q;
  logic [1:0]        quad_cur;
  qstep_t            step;
  logic signed [3:0] sub_q,   sub_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              dir_q,   dir_d;
  logic              tick_q,  tick_d;
  logic              limit_q, limit_d;
  logic              err_q,   err_d;
  logic              btn_prev_q;
  logic              btn_press_q;
  logic              up;
  logic              dn;
  logic [XW-1:0]     vx;
  logic [XW-1:0]     lvx;

  assign quad_cur = {a_f, b_f};
  assign step     = quad_step(quad_q, quad_cur);
  assign up       = step.valid && (step.delta == 2'sd1);
  assign dn       = step.valid && (step.delta == -2'sd1);
  // One extra bit of headroom keeps bound compares and +/-1 free of overflow.
  assign vx       = {1'b0, value_q};
  assign lvx      = {1'b0, bus.load_val};

  // Next value/sub-count/pulses: load beats a detent, a detent at a bound wraps or reports limit.
  always_comb begin
    value_d = value_q;
    sub_d   = sub_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    limit_d = 1'b0;
    err_d   = step.err;
    if (bus.load) begin
      sub_d = '0;
      if (lvx > MAXX) begin
        value_d = WIDTH'(MAXX);
      end else if (lvx < MINX) begin
        value_d = WIDTH'(MINX);
      end else begin
        value_d = bus.load_val;
      end
    end else if (up && (sub_q == SUB_TOP)) begin
      sub_d = '0;
      if (vx < MAXX) begin
        value_d = WIDTH'(vx + XW'(1));
        tick_d  = 1'b1;
        dir_d   = DIR_UP;
      end else if (WRAP != 0) begin
        value_d = WIDTH'(MINX);
        tick_d  = 1'b1;
        dir_d   = DIR_UP;
      end else begin
        limit_d = 1'b1;
      end
    end else if (dn && (sub_q == SUB_BOT)) begin
      sub_d = '0;
      if (vx > MINX) begin
        value_d = WIDTH'(vx - XW'(1));
        tick_d  = 1'b1;
        dir_d   = DIR_DN;
      end else if (WRAP != 0) begin
        value_d = WIDTH'(MAXX);
        tick_d  = 1'b1;
        dir_d   = DIR_DN;
      end else begin
        limit_d = 1'b1;
      end
    end else if (up) begin
      sub_d = sub_q + 4'sd1;
    end else if (dn) begin
      sub_d = sub_q - 4'sd1;
    end
  end

  // State and registered outputs; the quadrature state always follows the filtered pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quad_q      <= Q11;
      sub_q       <= '0;
      value_q     <= WIDTH'(RESET_VAL);
      dir_q       <= DIR_DN;
      tick_q      <= 1'b0;
      limit_q     <= 1'b0;
      err_q       <= 1'b0;
      btn_prev_q  <= 1'b1;
      btn_press_q <= 1'b0;
    end else begin
      quad_q      <= quad_cur;
      sub_q       <= sub_d;
      value_q     <= value_d;
      dir_q       <= dir_d;
      tick_q      <= tick_d;
      limit_q     <= limit_d;
      err_q       <= err_d;
      btn_prev_q  <= btn_f;
      btn_press_q <= btn_prev_q & ~btn_f;
    end
  end

  assign bus.value     = value_q;
  assign bus.dir       = dir_q;
  assign bus.tick      = tick_q;
  assign bus.limit     = limit_q;
  assign bus.err       = err_q;
  assign bus.btn_press = btn_press_q;

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// Purpose: scoreboard bench for three quad_enc_ctrl configurations (saturate, wrap, 9-bit clamp).
// Latency: expects pin events at drive cycle + 3 + FILT, load at drive cycle + 1.
// Backpressure: none; every unexpected output event is reported.
module tb_quad_enc_ctrl;

  localparam int LAT = 6;  // 3 + FILT with FILT = 3

  typedef struct {
    int cyc;
    bit tick;
    bit dir;
    bit limit;
    bit err;
    bit btn;
    int value;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic       a   [3];
  logic       b   [3];
  logic       btn [3];
  logic       ld  [3];
  logic [8:0] ldv [3];
  logic [1:0] st  [3];
  int         lastv [3];
  evt_t       q0[$];
  evt_t       q1[$];
  evt_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_enc_ctrl_if #(.WIDTH(8)) if0 ();
  quad_enc_ctrl_if #(.WIDTH(8)) if1 ();
  quad_enc_ctrl_if #(.WIDTH(9)) if2 ();

  assign if0.enc_a = a[0];  assign if0.enc_b = b[0];  assign if0.enc_btn = btn[0];
  assign if0.load  = ld[0]; assign if0.load_val = ldv[0][7:0];
  assign if1.enc_a = a[1];  assign if1.enc_b = b[1];  assign if1.enc_btn = btn[1];
  assign if1.load  = ld[1]; assign if1.load_val = ldv[1][7:0];
  assign if2.enc_a = a[2];  assign if2.enc_b = b[2];  assign if2.enc_btn = btn[2];
  assign if2.load  = ld[2]; assign if2.load_val = ldv[2];

  quad_enc_ctrl #(.WIDTH(8), .FILT(3), .STEPS(4), .MIN_VAL(0), .MAX_VAL(255),
                  .RESET_VAL(8), .WRAP(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  quad_enc_ctrl #(.WIDTH(8), .FILT(3), .STEPS(4), .MIN_VAL(0), .MAX_VAL(255),
                  .RESET_VAL(8), .WRAP(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  quad_enc_ctrl #(.WIDTH(9), .FILT(3), .STEPS(4), .MIN_VAL(5), .MAX_VAL(200),
                  .RESET_VAL(8), .WRAP(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic evt_t mk(input int c, input bit t, input bit dr, input bit l,
                              input bit e, input bit bp, input int v);
    evt_t x;
    x.cyc = c; x.tick = t; x.dir = dr; x.limit = l; x.err = e; x.btn = bp; x.value = v;
    return x;
  endfunction

  // Bench's own Gray-sequence walk: CW 00->01->11->10->00, CCW the reverse.
  function automatic logic [1:0] nxt(input logic [1:0] s, input bit up);
    case (s)
      2'b00:   return up ? 2'b01 : 2'b10;
      2'b01:   return up ? 2'b11 : 2'b00;
      2'b11:   return up ? 2'b10 : 2'b01;
      default: return up ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic push(input int d, input evt_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Monitor: any pulse or value change is an event that must match the head of that DUT's queue.
  task automatic mon(input int d, input bit t, input bit dr, input bit l, input bit e,
                     input bit bp, input int v);
    evt_t ex;
    bit   have;
    if (rst && (t || l || e || bp || v != lastv[d])) begin
      have = 1'b0;
      case (d)
        0:       if (q0.size() > 0) begin ex = q0.pop_front(); have = 1'b1; end
        1:       if (q1.size() > 0) begin ex = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin ex = q2.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL dut%0d_unexpected_event cyc=%0d: tick=%0b dir=%0b limit=%0b err=%0b btn=%0b value=%0d",
                 d, cyc, t, dr, l, e, bp, v);
      end else if (ex.cyc != cyc || ex.tick != t || ex.dir != dr || ex.limit != l ||
                   ex.err != e || ex.btn != bp || ex.value != v) begin
        errors++;
        $display("FAIL dut%0d_event got cyc=%0d tick=%0b dir=%0b limit=%0b err=%0b btn=%0b value=%0d, expected cyc=%0d tick=%0b dir=%0b limit=%0b err=%0b btn=%0b value=%0d",
                 d, cyc, t, dr, l, e, bp, v, ex.cyc, ex.tick, ex.dir, ex.limit, ex.err, ex.btn, ex.value);
      end
    end
    lastv[d] = v;
  endtask

  always @(negedge clk) begin
    mon(0, if0.tick, if0.dir, if0.limit, if0.err, if0.btn_press, int'(if0.value));
    mon(1, if1.tick, if1.dir, if1.limit, if1.err, if1.btn_press, int'(if1.value));
    mon(2, if2.tick, if2.dir, if2.limit, if2.err, if2.btn_press, int'(if2.value));
  end

  task automatic set_ab(input int d, input logic [1:0] ab);
    st[d] = ab;
    a[d]  = ab[1];
    b[d]  = ab[0];
  endtask

  // n single-bit transitions spaced 8 cycles; optional expected event after the last one.
  task automatic move(input int d, input bit up, input int n, input bit has_exp, input evt_t e);
    evt_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_ab(d, nxt(st[d], up));
      if (i == n - 1 && has_exp) begin
        x = e;
        x.cyc = cyc + LAT;
        push(d, x);
      end
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic do_load(input int d, input int v, input int expv, input bit dr);
    @(negedge clk);
    ld[d]  = 1'b1;
    ldv[d] = 9'(v);
    push(d, mk(cyc + 1, 1'b0, dr, 1'b0, 1'b0, 1'b0, expv));
    @(negedge clk);
    ld[d] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    evt_t nil;
    nil = mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      a[i] = 1'b1; b[i] = 1'b1; btn[i] = 1'b1; ld[i] = 1'b0; ldv[i] = '0; st[i] = 2'b11;
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_value0", int'(if0.value), 8);
    chk("rst_value1", int'(if1.value), 8);
    chk("rst_value2", int'(if2.value), 8);
    chk("rst_tick0",  int'(if0.tick), 0);
    chk("rst_dir0",   int'(if0.dir), 0);
    chk("rst_limit0", int'(if0.limit), 0);
    chk("rst_err0",   int'(if0.err), 0);
    chk("rst_btn0",   int'(if0.btn_press), 0);

    // dut0: 2-cycle glitch on A is filtered out
    @(negedge clk); a[0] = 1'b0;
    repeat (2) @(negedge clk); a[0] = 1'b1;
    repeat (10) @(negedge clk);
    // dut0: 11 -> 00 jump is illegal
    @(negedge clk); set_ab(0, 2'b00);
    push(0, mk(cyc + LAT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8));
    repeat (8) @(negedge clk);
    // dut0: one CW detent, then cancelled partial, then two CCW detents
    move(0, 1'b1, 4, 1'b1, mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9));
    move(0, 1'b1, 3, 1'b0, nil);
    move(0, 1'b0, 3, 1'b0, nil);
    move(0, 1'b0, 4, 1'b1, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8));
    move(0, 1'b0, 4, 1'b1, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7));
    // dut0: saturation at both bounds
    do_load(0, 255, 255, 1'b0);
    move(0, 1'b1, 4, 1'b1, mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 255));
    move(0, 1'b0, 4, 1'b1, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 254));
    do_load(0, 0, 0, 1'b0);
    move(0, 1'b0, 4, 1'b1, mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    move(0, 1'b1, 4, 1'b1, mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    // dut0: press, bounce while held, release, short bounce while released
    @(negedge clk); btn[0] = 1'b0;
    push(0, mk(cyc + LAT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1));
    repeat (10) @(negedge clk); btn[0] = 1'b1;
    repeat (2) @(negedge clk);  btn[0] = 1'b0;
    repeat (10) @(negedge clk); btn[0] = 1'b1;
    repeat (10) @(negedge clk); btn[0] = 1'b0;
    repeat (2) @(negedge clk);  btn[0] = 1'b1;
    repeat (10) @(negedge clk);

    // dut1: wrap in both directions
    do_load(1, 255, 255, 1'b0);
    move(1, 1'b1, 4, 1'b1, mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    move(1, 1'b0, 4, 1'b1, mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 255));

    // dut2: clamped load on the same edge as a detent wins, no tick
    move(2, 1'b1, 3, 1'b0, nil);
    @(negedge clk); set_ab(2, nxt(st[2], 1'b1)); k = cyc;
    repeat (5) @(negedge clk);
    ld[2] = 1'b1; ldv[2] = 9'd300;
    push(2, mk(k + LAT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 200));
    @(negedge clk); ld[2] = 1'b0;
    repeat (6) @(negedge clk);
    move(2, 1'b1, 4, 1'b1, mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 200));
    do_load(2, 2, 5, 1'b0);
    move(2, 1'b0, 4, 1'b1, mk(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5));
    // dut2: async reset mid-detent discards the partial count
    move(2, 1'b1, 3, 1'b0, nil);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_value2", int'(if2.value), 8);
    for (int i = 0; i < 3; i++) begin
      set_ab(i, 2'b11);
      btn[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_value0", int'(if0.value), 8);
    chk("post_rst_dir0",   int'(if0.dir), 0);
    move(2, 1'b1, 1, 1'b0, nil);
    move(2, 1'b1, 3, 1'b1, mk(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9));
    repeat (10) @(negedge clk);

    chk("dut0_events_drained", q0.size(), 0);
    chk("dut1_events_drained", q1.size(), 0);
    chk("dut2_events_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_enc_ctrl.md
# quad_enc_ctrl

Parametrised quadrature rotary-encoder controller for panel inputs. It synchronises and debounces the A/B/push-button pins and decodes full-resolution quadrature with invalid-transition detection. It maintains a bounded value register that saturates or wraps, and can be loaded from the host. It sits between the raw encoder pins and the front-panel/menu logic, and emits single-cycle event pulses for consumers.

## Interface
- `WIDTH`, 8: width of `value`.
- `FILT`, 3: consecutive identical synchronised samples required before a pin change is accepted (≥1).
- `STEPS`, 4: valid quadrature transitions per detent (1, 2 or 4).
- `MIN_VAL`, 0: lower bound of `value`.
- `MAX_VAL`, 255: upper bound of `value` (MIN_VAL < MAX_VAL ≤ 2^WIDTH−1).
- `RESET_VAL`, 8: `value` after reset.
- `WRAP`, 0: 0 = saturate at bounds, 1 = wrap MAX↔MIN.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `enc_a`, `enc_b` in 1: raw quadrature pins, asynchronous.
- `enc_btn` in 1: raw push-button, active-low (pressed = 0).
- `load` in 1: load `load_val` into `value` this cycle.
- `load_val` in WIDTH: load data; values outside MIN..MAX are clamped.
- `value` out WIDTH: current value (registered).
- `tick` out 1: one-cycle pulse when `value` changes by a detent step.
- `dir` out 1: direction of the last detent (1 = up/CW, 0 = down/CCW); holds between ticks.
- `limit` out 1: one-cycle pulse when a detent is refused because `value` is at a bound (WRAP=0 only).
- `btn_press` out 1: one-cycle pulse on the filtered press (1→0).
- `err` out 1: one-cycle pulse on an illegal quadrature transition (both bits change).

## Operation
- Each pin passes through a 2-flop synchroniser and then a stability filter. The filtered output changes only after `FILT` consecutive equal samples that differ from the current filtered level.
- Quadrature state {A,B} follows the Gray sequence 00→01→11→10→00 = CW (+1). The reverse sequence is CCW (−1).
  - Same state: no action.
  - Two-bit change: `err` pulse, no count; the state register still takes the new value.
- Signed sub-counter `sub` ranges over −(STEPS−1)..+(STEPS−1).
  - A +1 transition with sub = STEPS−1 is a detent up; a −1 transition with sub = −(STEPS−1) is a detent down.
  - A detent resets `sub` to 0. Otherwise `sub` moves ±1.
  - A direction reversal simply counts back, so partial detents cancel.
- Detent up:
  - value < MAX: value+1.
  - value = MAX: wraps to MIN if WRAP=1; otherwise no change, `limit` pulses, no `tick`.
- Detent down: mirror of detent up (value > MIN: value−1; at MIN, wrap to MAX or pulse `limit`).
- `tick` and `dir` update only when `value` actually changes due to a detent.
- `load` has priority over a simultaneous detent. The value is loaded (clamped), the detent is discarded, `sub` is cleared, and there is no `tick` or `limit`. `err` still reports.
- Arithmetic is performed in WIDTH+1 bits so bound compares never overflow.
- Reset (async, any time, including mid-detent):
  - `value`=RESET_VAL; `tick`, `limit`, `btn_press`, `err` = 0; `dir`=0; `sub`=0.
  - Synchroniser, filter and quadrature state registers reset to 1 (pins idle high). Filtered button = 1 (released).
  - Partial detents in progress are lost.

## Timing
- Latency: raw pin change stable from clock edge k → filtered level changes at edge k+2+FILT → `value`/`tick`/`dir`/`limit`/`err` registered at edge k+3+FILT. `btn_press` uses the same latency.
- Glitches shorter than FILT cycles (after synchronisation) produce no output.
- All outputs are registered; pulses last exactly one cycle.
- `load` takes effect at the next edge; `value` is visible the following cycle.
- One quadrature transition is processed per cycle at most. A/B filters are independent, so a simultaneous acceptance of both bits is an `err`.

## Structure
- Package `quad_enc_pkg`:
  - 2-bit quadrature state constants (Q00, Q01, Q11, Q10).
  - Direction constants DIR_UP/DIR_DN.
  - Function `quad_step(prev, cur)` returning {valid, err, ±1/0}.
- Sub-module `sync_filter` (param FILT, reset level): 2-flop synchroniser + stability counter, 1-bit in/out. Instantiated three times (A, B, button).
- The top level holds the decoder, sub-counter, bounded value register and pulse generation.

## Test plan
- Reset with defaults → value=8, all pulses 0; four clean CW transitions (spaced ≥FILT+3 cycles) → one `tick`, dir=1, value=9, at edge k+3+FILT after the last transition.
- WRAP=0, load 255, one CW detent → `limit` pulse, value stays 255, no `tick`. WRAP=1 → value=0, `tick`, dir=1.
- 2-cycle glitch on `enc_a` with FILT=3 → no state change, no pulses; a 00→11 jump → single `err`, value unchanged.
- Three CW transitions then three CCW transitions → value unchanged, no `tick`. Then four CCW transitions → value=7, dir=0.
- `load`=1 with `load_val`=300 (WIDTH=9, MAX_VAL=200) on the same cycle as a detent → value=200, no `tick`. Async `rst` low mid-detent → value=RESET_VAL immediately.
- Button held low ≥FILT+3 cycles → exactly one `btn_press`; bounce pulses shorter than FILT → none; release → no pulse.
